mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  Memory-access pipeline stage directly downstream of exe. Registers the ALU result, performs
//  loads/stores on the data-memory bus via a req/gnt/rvalid handshake, and presents one
//  writeback packet per instruction to wb. Stalls upstream while a memory access is in flight.
// PARAMETERS
//  DATA_W       32   datapath / register width
//  ADDR_W       32   data-memory byte address width
//  TIMEOUT_CYC  255  max cycles in WAIT before bus error (8-bit counter, must be 1..255)
// PORTS
//  clk_i          in   1       clock, rising edge
//  rst_n_i        in   1       asynchronous reset, active low
//  valid_i        in   1       exe output valid
//  reg_waddr_i    in   5       destination register from exe
//  reg_we_i       in   1       register write enable from exe
//  reg_wdata_i    in   DATA_W  ALU result; byte address for memory ops
//  mem_op_i       in   4       memory op (`MemOpBus), MEM_NONE for ALU ops
//  store_data_i   in   DATA_W  rs2 value for stores
//  stall_o        out  1       upstream must hold its outputs
//  dmem_req_o     out  1       bus request
//  dmem_we_o      out  1       1=write
//  dmem_addr_o    out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00})
//  dmem_be_o      out  4       byte enables
//  dmem_wdata_o   out  DATA_W  lane-steered store data
//  dmem_gnt_i     in   1       request accepted
//  dmem_rvalid_i  in   1       read data valid
//  dmem_rdata_i   in   DATA_W  read data
//  wb_valid_o     out  1       writeback packet valid (1 cycle)
//  wb_waddr_o     out  5       writeback register
//  wb_we_o        out  1       writeback enable (never 1 for x0)
//  wb_wdata_o     out  DATA_W  writeback data
//  bus_err_o      out  1       1-cycle pulse on load timeout
// BEHAVIOUR
//  Reset (async, rst_n_i=0): state IDLE, all outputs 0, timeout counter 0. Reset mid-access
//   abandons the transaction; no writeback is produced for it.
//  FSM IDLE/REQ/WAIT. stall_o = (state != IDLE); purely from state.
//  IDLE, valid_i & MEM_NONE: next cycle wb_valid_o=1 with exe fields (latency 1).
//  IDLE, valid_i & mem op: latch addr/op/data/waddr -> REQ. wb_valid_o=0 that next cycle.
//  REQ: dmem_req_o=1, addr/we/be/wdata held stable until dmem_gnt_i (gnt same cycle as req legal).
//   Store + gnt -> IDLE, wb_valid_o=1, wb_we_o=0 next cycle. Load + gnt -> WAIT, counter=0.
//  WAIT: dmem_req_o=0. rvalid -> IDLE; next cycle wb_valid_o=1, wb_we_o=latched we,
//   wb_wdata_o=extracted data. rvalid on the gnt cycle is ignored (bus contract: >=1 cycle later).
//   counter reaches TIMEOUT_CYC without rvalid -> IDLE, bus_err_o=1, wb_valid_o=1, wb_we_o=0.
//  Lane rules: LB/LBU select byte addr[1:0], LH/LHU half addr[1]; LB/LH sign-extend, LBU/LHU
//   zero-extend. SB be=4'b0001<<addr[1:0], data replicated x4; SH be=4'b0011<<{addr[1],1'b0},
//   data replicated x2; SW be=4'hF.
//  wb_we_o forced 0 when waddr==0. wb_valid_o is a 1-cycle pulse; wb has no backpressure.
//  valid_i ignored while state != IDLE (upstream is stalled).
// CONFIGURATION
//  MEM_MISALIGN_TRAP_EN defined: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, issue
//   no bus request; next cycle wb_valid_o=1, wb_we_o=0, bus_err_o=1; FSM stays IDLE.
//  Not defined: low address bits are truncated to natural alignment (half: addr[0]=0,
//   word: addr[1:0]=0) and the access proceeds normally; bus_err_o only from timeout.
// STRUCTURE
//  Shared package core_pkg: `MemOpBus width, MEM_NONE/LB/LH/LW/LBU/LHU/SB/SH/SW codes
//   (0..8), state encoding for IDLE/REQ/WAIT.
//  Sub-module lsu_align (combinational): store lane steering + byte enables, load
//   extraction + sign/zero extension. FSM, counter and registers stay in mem_stage.
// TESTING
//  ADD result 32'h0000_1234, waddr 5 -> 1 cycle later wb_valid=1, we=1, wdata=32'h0000_1234.
//  LB addr 32'h103, rdata 32'h80AA_BBCC, gnt immediate, rvalid 2 cycles later ->
//   wdata=32'hFFFF_FF80; LBU same -> 32'h0000_0080; stall_o high REQ..WAIT.
//  SH addr 32'h202, data 32'h0000_BEEF, gnt held low 3 cycles -> req/addr 32'h200/be 4'b1100/
//   wdata 32'hBEEF_BEEF stable all 4 cycles; wb_valid=1, we=0 after gnt.
//  LW, gnt, no rvalid -> after TIMEOUT_CYC cycles bus_err_o=1, wb_we=0, stall_o drops.
//  LW addr 32'h101: with MEM_MISALIGN_TRAP_EN no dmem_req, bus_err_o=1; without, addr 32'h100.
//  Load to waddr 0 -> wb_valid=1, wb_we=0; rst_n_i low in WAIT -> all outputs 0, no wb pulse.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the memory stage: memory-op codes, FSM state
// encoding and small op-classification helpers.
package core_pkg;

   localparam int MEM_OP_W = 4;

   typedef enum logic [MEM_OP_W-1:0] {
      MEM_NONE = 4'd0,
      MEM_LB   = 4'd1,
      MEM_LH   = 4'd2,
      MEM_LW   = 4'd3,
      MEM_LBU  = 4'd4,
      MEM_LHU  = 4'd5,
      MEM_SB   = 4'd6,
      MEM_SH   = 4'd7,
      MEM_SW   = 4'd8
   } mem_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } mem_state_e;

   // Codes outside LB..SW are treated as plain ALU ops.
   function automatic logic is_mem_op(input logic [MEM_OP_W-1:0] op);
      return (op >= MEM_LB) && (op <= MEM_SW);
   endfunction

   function automatic logic is_store(input logic [MEM_OP_W-1:0] op);
      return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
   endfunction

   // Halfword accesses need addr[0]=0, word accesses need addr[1:0]=0.
   function automatic logic is_misaligned(input logic [MEM_OP_W-1:0] op,
                                          input logic [1:0]          addr_lo);
      logic mis;
      mis = 1'b0;
      case (op)
         MEM_LH, MEM_LHU, MEM_SH: mis = addr_lo[0];
         MEM_LW, MEM_SW:          mis = (addr_lo != 2'b00);
         default:                 mis = 1'b0;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte enables and data replication,
// load byte/half extraction with sign or zero extension.
module lsu_align
   import core_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [MEM_OP_W-1:0] op_i,
   input  logic [1:0]          addr_lo_i,
   input  logic [DATA_W-1:0]   store_data_i,
   input  logic [DATA_W-1:0]   load_data_i,
   output logic [3:0]          be_o,
   output logic [DATA_W-1:0]   wdata_o,
   output logic [DATA_W-1:0]   rdata_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Lane selection is shared by loads and stores; only addr[1] matters for halves.
   always_comb begin
      byte_sel = load_data_i[{addr_lo_i, 3'b000} +: 8];
      half_sel = addr_lo_i[1] ? load_data_i[31:16] : load_data_i[15:0];
      be_o     = 4'b0000;
      wdata_o  = '0;
      rdata_o  = '0;
      case (op_i)
         MEM_LB: begin
            be_o    = 4'b0001 << addr_lo_i;
            rdata_o = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
         end
         MEM_LBU: begin
            be_o    = 4'b0001 << addr_lo_i;
            rdata_o = {{(DATA_W-8){1'b0}}, byte_sel};
         end
         MEM_LH: begin
            be_o    = 4'b0011 << {addr_lo_i[1], 1'b0};
            rdata_o = {{(DATA_W-16){half_sel[15]}}, half_sel};
         end
         MEM_LHU: begin
            be_o    = 4'b0011 << {addr_lo_i[1], 1'b0};
            rdata_o = {{(DATA_W-16){1'b0}}, half_sel};
         end
         MEM_LW: begin
            be_o    = 4'hF;
            rdata_o = load_data_i;
         end
         MEM_SB: begin
            be_o    = 4'b0001 << addr_lo_i;
            wdata_o = {(DATA_W/8){store_data_i[7:0]}};
         end
         MEM_SH: begin
            be_o    = 4'b0011 << {addr_lo_i[1], 1'b0};
            wdata_o = {(DATA_W/16){store_data_i[15:0]}};
         end
         MEM_SW: begin
            be_o    = 4'hF;
            wdata_o = store_data_i;
         end
         default: begin
            be_o = 4'b0000;
         end
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: registers ALU results, runs loads/stores on a
// req/gnt/rvalid data bus and emits one writeback pulse per instruction.
// Optional feature macro: MEM_MISALIGN_TRAP_EN (trap misaligned accesses
// instead of truncating the low address bits).
// Bus handshake: dmem_req_o stays high with addr/we/be/wdata stable until a
// cycle where dmem_gnt_i is also high; read data is accepted on dmem_rvalid_i
// no earlier than the cycle after the grant.
module mem_stage
   import core_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 32,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic                clk_i,
   input  logic                rst_n_i,
   input  logic                valid_i,
   input  logic [4:0]          reg_waddr_i,
   input  logic                reg_we_i,
   input  logic [DATA_W-1:0]   reg_wdata_i,
   input  logic [MEM_OP_W-1:0] mem_op_i,
   input  logic [DATA_W-1:0]   store_data_i,
   output logic                stall_o,
   output logic                dmem_req_o,
   output logic                dmem_we_o,
   output logic [ADDR_W-1:0]   dmem_addr_o,
   output logic [3:0]          dmem_be_o,
   output logic [DATA_W-1:0]   dmem_wdata_o,
   input  logic                dmem_gnt_i,
   input  logic                dmem_rvalid_i,
   input  logic [DATA_W-1:0]   dmem_rdata_i,
   output logic                wb_valid_o,
   output logic [4:0]          wb_waddr_o,
   output logic                wb_we_o,
   output logic [DATA_W-1:0]   wb_wdata_o,
   output logic                bus_err_o,
   output logic [1:0]          dbg_state_o
);

   localparam logic [7:0] TIMEOUT_LIM = TIMEOUT_CYC[7:0];

   mem_state_e          state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [MEM_OP_W-1:0] op_q, op_d;
   logic [DATA_W-1:0]   sdata_q, sdata_d;
   logic [4:0]          waddr_q, waddr_d;
   logic                we_q, we_d;
   logic [7:0]          cnt_q, cnt_d;
   logic                wb_valid_q, wb_valid_d;
   logic [4:0]          wb_waddr_q, wb_waddr_d;
   logic                wb_we_q, wb_we_d;
   logic [DATA_W-1:0]   wb_wdata_q, wb_wdata_d;
   logic                bus_err_q, bus_err_d;

   logic                trap;
   logic [7:0]          cnt_inc;
   logic [3:0]          lsu_be;
   logic [DATA_W-1:0]   lsu_wdata;
   logic [DATA_W-1:0]   lsu_rdata;

   lsu_align #(.DATA_W(DATA_W)) u_lsu_align (
      .op_i         (op_q),
      .addr_lo_i    (addr_q[1:0]),
      .store_data_i (sdata_q),
      .load_data_i  (dmem_rdata_i),
      .be_o         (lsu_be),
      .wdata_o      (lsu_wdata),
      .rdata_o      (lsu_rdata)
   );

   // Next-state, operand latching and writeback packet formation.
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      op_d       = op_q;
      sdata_d    = sdata_q;
      waddr_d    = waddr_q;
      we_d       = we_q;
      cnt_d      = cnt_q;
      wb_valid_d = 1'b0;
      wb_waddr_d = 5'd0;
      wb_we_d    = 1'b0;
      wb_wdata_d = '0;
      bus_err_d  = 1'b0;
      cnt_inc    = cnt_q + 8'd1;
`ifdef MEM_MISALIGN_TRAP_EN
      trap = is_misaligned(mem_op_i, reg_wdata_i[1:0]);
`else
      trap = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (valid_i) begin
               if (!is_mem_op(mem_op_i)) begin
                  wb_valid_d = 1'b1;
                  wb_waddr_d = reg_waddr_i;
                  wb_we_d    = reg_we_i && (reg_waddr_i != 5'd0);
                  wb_wdata_d = reg_wdata_i;
               end else if (trap) begin
                  wb_valid_d = 1'b1;
                  wb_waddr_d = reg_waddr_i;
                  bus_err_d  = 1'b1;
               end else begin
                  addr_d  = reg_wdata_i[ADDR_W-1:0];
                  op_d    = mem_op_i;
                  sdata_d = store_data_i;
                  waddr_d = reg_waddr_i;
                  we_d    = reg_we_i;
                  state_d = ST_REQ;
               end
            end
         end
         ST_REQ: begin
            if (dmem_gnt_i) begin
               if (is_store(op_q)) begin
                  state_d    = ST_IDLE;
                  wb_valid_d = 1'b1;
                  wb_waddr_d = waddr_q;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = 8'd0;
               end
            end
         end
         ST_WAIT: begin
            if (dmem_rvalid_i) begin
               state_d    = ST_IDLE;
               wb_valid_d = 1'b1;
               wb_waddr_d = waddr_q;
               wb_we_d    = we_q && (waddr_q != 5'd0);
               wb_wdata_d = lsu_rdata;
            end else if (cnt_inc == TIMEOUT_LIM) begin
               state_d    = ST_IDLE;
               wb_valid_d = 1'b1;
               wb_waddr_d = waddr_q;
               bus_err_d  = 1'b1;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Bus and status outputs are decoded from registered state only.
   always_comb begin
      stall_o      = (state_q != ST_IDLE);
      dmem_req_o   = (state_q == ST_REQ);
      dmem_we_o    = dmem_req_o && is_store(op_q);
      dmem_addr_o  = dmem_req_o ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
      dmem_be_o    = dmem_req_o ? lsu_be : 4'b0000;
      dmem_wdata_o = dmem_req_o ? lsu_wdata : '0;
      wb_valid_o   = wb_valid_q;
      wb_waddr_o   = wb_waddr_q;
      wb_we_o      = wb_we_q;
      wb_wdata_o   = wb_wdata_q;
      bus_err_o    = bus_err_q;
      dbg_state_o  = state_q;
   end

   // State and datapath registers; reset abandons any in-flight access.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q    <= ST_IDLE;
         addr_q     <= '0;
         op_q       <= '0;
         sdata_q    <= '0;
         waddr_q    <= 5'd0;
         we_q       <= 1'b0;
         cnt_q      <= 8'd0;
         wb_valid_q <= 1'b0;
         wb_waddr_q <= 5'd0;
         wb_we_q    <= 1'b0;
         wb_wdata_q <= '0;
         bus_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         op_q       <= op_d;
         sdata_q    <= sdata_d;
         waddr_q    <= waddr_d;
         we_q       <= we_d;
         cnt_q      <= cnt_d;
         wb_valid_q <= wb_valid_d;
         wb_waddr_q <= wb_waddr_d;
         wb_we_q    <= wb_we_d;
         wb_wdata_q <= wb_wdata_d;
         bus_err_q  <= bus_err_d;
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage with an expected-packet scoreboard.
module tb_mem_stage;

   localparam int TO = 16;

   localparam logic [3:0] OP_NONE = 4'd0;
   localparam logic [3:0] OP_LB   = 4'd1;
   localparam logic [3:0] OP_LH   = 4'd2;
   localparam logic [3:0] OP_LW   = 4'd3;
   localparam logic [3:0] OP_LBU  = 4'd4;
   localparam logic [3:0] OP_LHU  = 4'd5;
   localparam logic [3:0] OP_SB   = 4'd6;
   localparam logic [3:0] OP_SH   = 4'd7;
   localparam logic [3:0] OP_SW   = 4'd8;

   logic        clk;
   logic        rst_n;
   logic        valid_i;
   logic [4:0]  reg_waddr;
   logic        reg_we;
   logic [31:0] reg_wdata;
   logic [3:0]  mem_op;
   logic [31:0] store_data;
   logic        stall;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_wdata;
   logic        dmem_gnt;
   logic        dmem_rvalid;
   logic [31:0] dmem_rdata;
   logic        wb_valid;
   logic [4:0]  wb_waddr;
   logic        wb_we;
   logic [31:0] wb_wdata;
   logic        bus_err;
   logic [1:0]  dbg_state;

   mem_stage #(.DATA_W(32), .ADDR_W(32), .TIMEOUT_CYC(TO)) dut (
      .clk_i         (clk),
      .rst_n_i       (rst_n),
      .valid_i       (valid_i),
      .reg_waddr_i   (reg_waddr),
      .reg_we_i      (reg_we),
      .reg_wdata_i   (reg_wdata),
      .mem_op_i      (mem_op),
      .store_data_i  (store_data),
      .stall_o       (stall),
      .dmem_req_o    (dmem_req),
      .dmem_we_o     (dmem_we),
      .dmem_addr_o   (dmem_addr),
      .dmem_be_o     (dmem_be),
      .dmem_wdata_o  (dmem_wdata),
      .dmem_gnt_i    (dmem_gnt),
      .dmem_rvalid_i (dmem_rvalid),
      .dmem_rdata_i  (dmem_rdata),
      .wb_valid_o    (wb_valid),
      .wb_waddr_o    (wb_waddr),
      .wb_we_o       (wb_we),
      .wb_wdata_o    (wb_wdata),
      .bus_err_o     (bus_err),
      .dbg_state_o   (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard ----------------
   typedef struct packed {
      logic        err;
      logic        we;
      logic [4:0]  waddr;
      logic [31:0] wdata;
   } wb_pkt_t;

   wb_pkt_t exp_q[$];
   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic wb_pkt_t pkt(input logic err, input logic we, input logic [4:0] waddr,
                                   input logic [31:0] wdata);
      wb_pkt_t p;
      p.err   = err;
      p.we    = we;
      p.waddr = waddr;
      p.wdata = wdata;
      return p;
   endfunction

   // Monitor: every writeback or error pulse must match the oldest expectation.
   always @(negedge clk) begin
      wb_pkt_t e;
      if (rst_n && (wb_valid || bus_err)) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_wb: got valid=%0b err=%0b waddr=%0d we=%0b data=%0h, expected none",
                     wb_valid, bus_err, wb_waddr, wb_we, wb_wdata);
         end else begin
            e = exp_q.pop_front();
            check("wb_valid", 128'(wb_valid), 128'(1'b1));
            check("wb_bus_err", 128'(bus_err), 128'(e.err));
            check("wb_we", 128'(wb_we), 128'(e.we));
            check("wb_waddr", 128'(wb_waddr), 128'(e.waddr));
            if (e.we) check("wb_wdata", 128'(wb_wdata), 128'(e.wdata));
         end
      end
   end

   // ---------------- driver tasks ----------------
   // All tasks start and end 1 time unit after a rising edge.
   task automatic issue(input logic [3:0] op, input logic [4:0] waddr, input logic we,
                        input logic [31:0] wdata, input logic [31:0] sdata);
      valid_i    = 1'b1;
      mem_op     = op;
      reg_waddr  = waddr;
      reg_we     = we;
      reg_wdata  = wdata;
      store_data = sdata;
      @(posedge clk); #1;
      valid_i    = 1'b0;
      mem_op     = OP_NONE;
      reg_waddr  = 5'd0;
      reg_we     = 1'b0;
      reg_wdata  = 32'h0;
      store_data = 32'h0;
   endtask

   task automatic check_req(input string tag, input logic st, input logic [31:0] a,
                            input logic [3:0] be, input logic [31:0] wd);
      @(negedge clk);
      check({tag, "_stall_req_we"}, 128'({stall, dmem_req, dmem_we}), 128'({2'b11, st}));
      check({tag, "_addr"}, 128'(dmem_addr), 128'(a));
      if (st) begin
         check({tag, "_be"}, 128'(dmem_be), 128'(be));
         check({tag, "_wdata"}, 128'(dmem_wdata), 128'(wd));
      end
   endtask

   // One memory access: grant after gnt_wait cycles, rvalid rv_wait cycles after grant.
   task automatic do_mem(input string tag, input logic [3:0] op, input logic [4:0] waddr,
                         input logic [31:0] addr, input logic [31:0] sdata, input int gnt_wait,
                         input int rv_wait, input logic [31:0] rdata, input logic rv_on_gnt,
                         input logic busy_valid, input logic [31:0] exp_addr,
                         input logic [3:0] exp_be, input logic [31:0] exp_wd);
      logic st;
      st = (op >= OP_SB);
      issue(op, waddr, !st, addr, sdata);
      if (busy_valid) begin
         // A competing ALU op while stalled must be ignored.
         valid_i   = 1'b1;
         mem_op    = OP_NONE;
         reg_waddr = 5'd31;
         reg_we    = 1'b1;
         reg_wdata = 32'h0BAD_0BAD;
      end
      for (int i = 0; i < gnt_wait; i++) begin
         check_req(tag, st, exp_addr, exp_be, exp_wd);
         @(posedge clk); #1;
      end
      dmem_gnt = 1'b1;
      if (rv_on_gnt) begin
         dmem_rvalid = 1'b1;
         dmem_rdata  = 32'hFFFF_FFFF;
      end
      check_req(tag, st, exp_addr, exp_be, exp_wd);
      @(posedge clk); #1;
      dmem_gnt    = 1'b0;
      dmem_rvalid = 1'b0;
      dmem_rdata  = 32'h0;
      valid_i     = 1'b0;
      reg_waddr   = 5'd0;
      reg_we      = 1'b0;
      reg_wdata   = 32'h0;
      if (!st) begin
         for (int i = 1; i < rv_wait; i++) begin
            @(negedge clk);
            check({tag, "_wait_stall_req"}, 128'({stall, dmem_req}), 128'(2'b10));
            @(posedge clk); #1;
         end
         dmem_rvalid = 1'b1;
         dmem_rdata  = rdata;
         @(negedge clk);
         check({tag, "_rvalid_stall"}, 128'(stall), 128'(1'b1));
         @(posedge clk); #1;
         dmem_rvalid = 1'b0;
         dmem_rdata  = 32'h0;
      end
      @(negedge clk);
      check({tag, "_done_stall"}, 128'(stall), 128'(1'b0));
      @(posedge clk); #1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int cyc;
      rst_n       = 1'b0;
      valid_i     = 1'b0;
      reg_waddr   = 5'd0;
      reg_we      = 1'b0;
      reg_wdata   = 32'h0;
      mem_op      = OP_NONE;
      store_data  = 32'h0;
      dmem_gnt    = 1'b0;
      dmem_rvalid = 1'b0;
      dmem_rdata  = 32'h0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_outputs",
            128'({stall, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
                  wb_valid, wb_waddr, wb_we, wb_wdata, bus_err}), 128'(0));
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // ALU ops: one-cycle latency, x0 and we=0 suppress the write.
      exp_q.push_back(pkt(1'b0, 1'b1, 5'd5, 32'h0000_1234));
      issue(OP_NONE, 5'd5, 1'b1, 32'h0000_1234, 32'h0);
      @(negedge clk);
      check("alu_stall", 128'(stall), 128'(1'b0));
      @(posedge clk); #1;
      exp_q.push_back(pkt(1'b0, 1'b0, 5'd0, 32'h0));
      issue(OP_NONE, 5'd0, 1'b1, 32'h0000_5555, 32'h0);
      exp_q.push_back(pkt(1'b0, 1'b0, 5'd6, 32'h0));
      issue(OP_NONE, 5'd6, 1'b0, 32'h0000_7777, 32'h0);
      @(posedge clk); #1;

      // Loads with lane extraction; first one also drives a spurious rvalid on the gnt cycle.
      exp_q.push_back(pkt(1'b0, 1'b1, 5'd7, 32'hFFFF_FF80));
      do_mem("lb", OP_LB, 5'd7, 32'h103, 32'h0, 0, 2, 32'h80AA_BBCC, 1'b1, 1'b0,
             32'h100, 4'h0, 32'h0);
      exp_q.push_back(pkt(1'b0, 1'b1, 5'd8, 32'h0000_0080));
      do_mem("lbu", OP_LBU, 5'd8, 32'h103, 32'h0, 0, 2, 32'h80AA_BBCC, 1'b0, 1'b0,
             32'h100, 4'h0, 32'h0);
      exp_q.push_back(pkt(1'b0, 1'b1, 5'd10, 32'hFFFF_80AA));
      do_mem("lh", OP_LH, 5'd10, 32'h102, 32'h0, 1, 1, 32'h80AA_BBCC, 1'b0, 1'b0,
             32'h100, 4'h0, 32'h0);
      exp_q.push_back(pkt(1'b0, 1'b1, 5'd12, 32'h0000_80AA));
      do_mem("lhu", OP_LHU, 5'd12, 32'h102, 32'h0, 0, 3, 32'h80AA_BBCC, 1'b0, 1'b0,
             32'h100, 4'h0, 32'h0);

      // Stores: request fields held stable across a delayed grant.
      exp_q.push_back(pkt(1'b0, 1'b0, 5'd0, 32'h0));
      do_mem("sh", OP_SH, 5'd0, 32'h202, 32'h0000_BEEF, 3, 0, 32'h0, 1'b0, 1'b1,
             32'h200, 4'b1100, 32'hBEEF_BEEF);
      exp_q.push_back(pkt(1'b0, 1'b0, 5'd0, 32'h0));
      do_mem("sb", OP_SB, 5'd0, 32'h101, 32'h0000_005A, 0, 0, 32'h0, 1'b0, 1'b0,
             32'h100, 4'b0010, 32'h5A5A_5A5A);
      exp_q.push_back(pkt(1'b0, 1'b0, 5'd0, 32'h0));
      do_mem("sw", OP_SW, 5'd0, 32'h010, 32'hDEAD_BEEF, 1, 0, 32'h0, 1'b0, 1'b0,
             32'h010, 4'hF, 32'hDEAD_BEEF);

      // Load into x0: packet is produced but never writes.
      exp_q.push_back(pkt(1'b0, 1'b0, 5'd0, 32'h0));
      do_mem("lw_x0", OP_LW, 5'd0, 32'h400, 32'h0, 0, 1, 32'h1234_5678, 1'b0, 1'b0,
             32'h400, 4'h0, 32'h0);

      // Misaligned word load.
`ifdef MEM_MISALIGN_TRAP_EN
      exp_q.push_back(pkt(1'b1, 1'b0, 5'd11, 32'h0));
      issue(OP_LW, 5'd11, 1'b1, 32'h101, 32'h0);
      @(negedge clk);
      check("mis_no_req", 128'({stall, dmem_req}), 128'(2'b00));
      @(posedge clk); #1;
`else
      exp_q.push_back(pkt(1'b0, 1'b1, 5'd11, 32'h1122_3344));
      do_mem("mis_lw", OP_LW, 5'd11, 32'h101, 32'h0, 0, 1, 32'h1122_3344, 1'b0, 1'b0,
             32'h100, 4'h0, 32'h0);
`endif

      // Timeout: granted load with no rvalid stays in WAIT for TO cycles.
      exp_q.push_back(pkt(1'b1, 1'b0, 5'd9, 32'h0));
      issue(OP_LW, 5'd9, 1'b1, 32'h300, 32'h0);
      dmem_gnt = 1'b1;
      check_req("to", 1'b0, 32'h300, 4'h0, 32'h0);
      @(posedge clk); #1;
      dmem_gnt = 1'b0;
      cyc = 0;
      while (cyc < 100) begin
         @(negedge clk);
         if (!stall) break;
         cyc++;
         @(posedge clk); #1;
      end
      check("timeout_wait_cycles", 128'(cyc), 128'(TO));
      @(posedge clk); #1;

      // Reset while waiting for read data: everything clears, no writeback later.
      issue(OP_LW, 5'd3, 1'b1, 32'h500, 32'h0);
      dmem_gnt = 1'b1;
      @(posedge clk); #1;
      dmem_gnt = 1'b0;
      @(negedge clk);
      check("rst_mid_stall_before", 128'(stall), 128'(1'b1));
      rst_n = 1'b0;
      #1;
      check("rst_mid_outputs",
            128'({stall, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
                  wb_valid, wb_waddr, wb_we, wb_wdata, bus_err}), 128'(0));
      @(posedge clk); #1;
      dmem_rvalid = 1'b1;
      dmem_rdata  = 32'hAAAA_AAAA;
      rst_n = 1'b1;
      @(posedge clk); #1;
      dmem_rvalid = 1'b0;
      dmem_rdata  = 32'h0;
      repeat (3) @(posedge clk);
      #1;

      // Still alive after reset.
      exp_q.push_back(pkt(1'b0, 1'b1, 5'd4, 32'h0000_CAFE));
      issue(OP_NONE, 5'd4, 1'b1, 32'h0000_CAFE, 32'h0);
      repeat (3) @(posedge clk);
      #1;
      check("queue_empty", 128'(exp_q.size()), 128'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
